// File: rtl/qdr_ram_responder.sv
// qdr_ram_responder
//   On-chip stand-in for a QDR controller plus SRAM on the 18-bit address /
//   wide-data user interface. Reads return after a fixed, fully pipelined
//   latency. Reads that match a programmable address can be corrupted with an
//   XOR mask, so that a BIST can be shown to report failures.
//
// Parameters
//   ADDR_BITS   storage index width, depth = 2**ADDR_BITS (1..18)
//   DATA_WIDTH  word width
//   RD_LATENCY  edges from read sample to ram_rd_valid (1..30)
//
// Ports
//   clk, rst                    single clock, synchronous active-high reset
//   ram_rd_en / ram_rd_addr     read request, one per cycle
//   ram_rd_valid / ram_rd_data  one-cycle response pulse, data held otherwise
//   ram_wr_en / ram_wr_addr /
//   ram_wr_data                 write request, one per cycle
//   fault_en / fault_addr /
//   fault_mask                  XOR mask on reads of exactly fault_addr
//   rd_count / wr_count         saturating accepted-request counters
//   busy                        a read is in flight and not yet presented
module qdr_ram_responder #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned RD_LATENCY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_rd_en,
  input  logic [17:0]           ram_rd_addr,
  output logic                  ram_rd_valid,
  output logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  ram_wr_en,
  input  logic [17:0]           ram_wr_addr,
  input  logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic                  fault_en,
  input  logic [17:0]           fault_addr,
  input  logic [DATA_WIDTH-1:0] fault_mask,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_accept;
  logic                  wr_accept;
  logic [ADDR_BITS-1:0]  rd_idx;
  logic [ADDR_BITS-1:0]  wr_idx;
  logic                  fault_hit;

  // Registered array read: raw word plus the mask selected at the same edge.
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] rd_raw_q,  rd_raw_d;
  logic [DATA_WIDTH-1:0] rd_xor_q,  rd_xor_d;

  // Latency pipeline; index RD_LATENCY-1 is the output stage.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [RD_LATENCY];

  logic [31:0]           rd_count_q, rd_count_d;
  logic [31:0]           wr_count_q, wr_count_d;

  // Upper write-address bits only alias onto the same storage word.
  logic                  unused_wr_addr;
  assign unused_wr_addr = ^ram_wr_addr;

  always_comb begin
    rd_accept = ram_rd_en & ~rst;
    wr_accept = ram_wr_en & ~rst;
    rd_idx    = ram_rd_addr[ADDR_BITS-1:0];
    wr_idx    = ram_wr_addr[ADDR_BITS-1:0];
    // Fault match is on the full 18-bit address, so aliases are not hit.
    fault_hit = fault_en && (ram_rd_addr == fault_addr);

    rd_pend_d = rd_accept;
    rd_raw_d  = mem[rd_idx];
    rd_xor_d  = fault_hit ? fault_mask : '0;
  end

  // Each stage only loads when a valid word arrives, so the output stage
  // keeps presenting its last data between pulses.
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = rd_pend_q;
    if (rd_pend_q) begin
      dat_d[0] = rd_raw_q ^ rd_xor_q;
    end
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_accept && (rd_count_q != '1)) begin
      rd_count_d = rd_count_q + 32'd1;
    end
    if (wr_accept && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  // The output stage is excluded: once presented, a read is no longer in flight.
  always_comb begin
    busy = rd_pend_q;
    for (int unsigned i = 0; i + 1 < RD_LATENCY; i++) begin
      busy = busy | vld_q[i];
    end
  end

  always_comb begin
    ram_rd_valid = vld_q[RD_LATENCY-1];
    ram_rd_data  = dat_q[RD_LATENCY-1];
    rd_count     = rd_count_q;
    wr_count     = wr_count_q;
  end

  // Storage: read (above) and write at the same edge give read-before-write.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_idx] <= ram_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_raw_q <= rd_raw_d;
    rd_xor_q <= rd_xor_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      vld_q      <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_qdr_ram_responder.sv
// Bench for qdr_ram_responder: hand-derived vector table, directed sequences
// for multi-cycle corners, a second instance at RD_LATENCY=1/ADDR_BITS=4, and
// randomized traffic against a queue-based reference model.
module tb_qdr_ram_responder;

  localparam int unsigned L  = 8;
  localparam int unsigned AB = 10;
  localparam int unsigned DW = 144;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_rd_en;
  logic [17:0]   ram_rd_addr;
  logic          ram_rd_valid;
  logic [DW-1:0] ram_rd_data;
  logic          ram_wr_en;
  logic [17:0]   ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          fault_en;
  logic [17:0]   fault_addr;
  logic [DW-1:0] fault_mask;
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
  logic          busy;

  logic          b_rd_en;
  logic [17:0]   b_rd_addr;
  logic          b_rd_valid;
  logic [DW-1:0] b_rd_data;
  logic          b_wr_en;
  logic [17:0]   b_wr_addr;
  logic [DW-1:0] b_wr_data;
  logic [31:0]   b_rd_count;
  logic [31:0]   b_wr_count;
  logic          b_busy;

  always #5 clk = ~clk;

  qdr_ram_responder #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .fault_en(fault_en), .fault_addr(fault_addr), .fault_mask(fault_mask),
    .rd_count(rd_count), .wr_count(wr_count), .busy(busy)
  );

  qdr_ram_responder #(.ADDR_BITS(4), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .ram_rd_en(b_rd_en), .ram_rd_addr(b_rd_addr),
    .ram_rd_valid(b_rd_valid), .ram_rd_data(b_rd_data),
    .ram_wr_en(b_wr_en), .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data),
    .fault_en(1'b0), .fault_addr(18'd0), .fault_mask({DW{1'b0}}),
    .rd_count(b_rd_count), .wr_count(b_wr_count), .busy(b_busy)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } resp_t;

  logic [DW-1:0] mmem [1 << AB];
  resp_t         rq [$];
  int unsigned   cyc = 0;
  logic [DW-1:0] m_last = '0;
  logic [31:0]   m_rd = '0;
  logic [31:0]   m_wr = '0;

  bit            rec_on = 1'b0;
  logic [DW-1:0] rec_data [$];
  int unsigned   rec_cyc [$];

  // Applies the request present at the edge just taken.
  task automatic model_edge();
    logic [DW-1:0] d;
    cyc++;
    if (rst) begin
      rq.delete();
      m_rd   = '0;
      m_wr   = '0;
      m_last = '0;
    end else begin
      if (ram_rd_en) begin
        d = mmem[ram_rd_addr % (1 << AB)];
        if (fault_en && fault_addr == ram_rd_addr) d = d ^ fault_mask;
        rq.push_back('{due: cyc + L, data: d});
        if (m_rd != 32'hffffffff) m_rd++;
      end
      if (ram_wr_en) begin
        mmem[ram_wr_addr % (1 << AB)] = ram_wr_data;
        if (m_wr != 32'hffffffff) m_wr++;
      end
    end
  endtask

  task automatic model_check();
    bit exp_v;
    exp_v = (rq.size() > 0) && (rq[0].due == cyc);
    if (exp_v) begin
      m_last = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rd_valid", DW'(ram_rd_valid), DW'(exp_v));
    chk("rd_data", ram_rd_data, m_last);
    chk("busy", DW'(busy), DW'(rq.size() != 0));
    chk("rd_count", DW'(rd_count), DW'(m_rd));
    chk("wr_count", DW'(wr_count), DW'(m_wr));
    if (rec_on && ram_rd_valid === 1'b1) begin
      rec_data.push_back(ram_rd_data);
      rec_cyc.push_back(cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic idle_inputs();
    ram_rd_en  = 1'b0;
    ram_wr_en  = 1'b0;
    fault_en   = 1'b0;
    fault_addr = '0;
    fault_mask = '0;
    b_rd_en    = 1'b0;
    b_wr_en    = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr_en;
    logic [17:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [17:0]   rd_addr;
    logic          f_en;
    logic [17:0]   f_addr;
    logic [DW-1:0] f_mask;
    logic [DW-1:0] exp_data;
    logic [31:0]   exp_rd;
    logic [31:0]   exp_wr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [DW-1:0] a5;
    logic [DW-1:0] ones;
    logic [DW-1:0] dead;
    a5   = {18{8'hA5}};
    ones = '1;
    dead = {36{4'hD}};

    vecs[0]  = '{1'b1, 18'd5,    a5,      1'b0, 18'd0,    1'b0, 18'd0,    144'd0, 144'd0,  32'd0, 32'd1};
    vecs[1]  = '{1'b0, 18'd0,    144'd0,  1'b1, 18'd5,    1'b0, 18'd0,    144'd0, a5,      32'd1, 32'd1};
    vecs[2]  = '{1'b1, 18'd7,    144'd1,  1'b0, 18'd0,    1'b0, 18'd0,    144'd0, 144'd0,  32'd1, 32'd2};
    vecs[3]  = '{1'b1, 18'd7,    144'd2,  1'b1, 18'd7,    1'b0, 18'd0,    144'd0, 144'd1,  32'd2, 32'd3};
    vecs[4]  = '{1'b0, 18'd0,    144'd0,  1'b1, 18'd7,    1'b0, 18'd0,    144'd0, 144'd2,  32'd3, 32'd3};
    vecs[5]  = '{1'b1, 18'd3,    144'd0,  1'b0, 18'd0,    1'b0, 18'd0,    144'd0, 144'd0,  32'd3, 32'd4};
    vecs[6]  = '{1'b0, 18'd0,    144'd0,  1'b1, 18'd3,    1'b1, 18'd3,    144'd1, 144'd1,  32'd4, 32'd4};
    vecs[7]  = '{1'b0, 18'd0,    144'd0,  1'b1, 18'd1027, 1'b1, 18'd3,    144'd1, 144'd0,  32'd5, 32'd4};
    vecs[8]  = '{1'b0, 18'd0,    144'd0,  1'b1, 18'd3,    1'b0, 18'd3,    144'd1, 144'd0,  32'd6, 32'd4};
    vecs[9]  = '{1'b0, 18'd0,    144'd0,  1'b1, 18'd1029, 1'b0, 18'd0,    144'd0, a5,      32'd7, 32'd4};
    vecs[10] = '{1'b0, 18'd0,    144'd0,  1'b1, 18'd1027, 1'b1, 18'd1027, ones,   ones,    32'd8, 32'd4};

    idle_inputs();
    ram_rd_addr = '0; ram_wr_addr = '0; ram_wr_data = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // ---- table: single transactions with hand-derived responses ----
    foreach (vecs[n]) begin
      ram_wr_en   = vecs[n].wr_en;
      ram_wr_addr = vecs[n].wr_addr;
      ram_wr_data = vecs[n].wr_data;
      ram_rd_en   = vecs[n].rd_en;
      ram_rd_addr = vecs[n].rd_addr;
      fault_en    = vecs[n].f_en;
      fault_addr  = vecs[n].f_addr;
      fault_mask  = vecs[n].f_mask;
      tick();
      idle_inputs();
      chk("tbl_rd_count", DW'(rd_count), DW'(vecs[n].exp_rd));
      chk("tbl_wr_count", DW'(wr_count), DW'(vecs[n].exp_wr));
      for (int k = 1; k <= int'(L); k++) begin
        tick();
        if (k < int'(L) && vecs[n].rd_en) chk("tbl_early", DW'(ram_rd_valid), 144'd0);
      end
      if (vecs[n].rd_en) begin
        chk("tbl_valid", DW'(ram_rd_valid), 144'd1);
        chk("tbl_data", ram_rd_data, vecs[n].exp_data);
      end
      tick();
      chk("tbl_pulse_end", DW'(ram_rd_valid), 144'd0);
    end

    // ---- 16 writes then 16 back-to-back reads ----
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ram_wr_en = 1'b1; ram_wr_addr = 18'(i); ram_wr_data = DW'(i);
      tick();
    end
    idle_inputs();
    rec_data.delete(); rec_cyc.delete();
    rec_on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ram_rd_en = 1'b1; ram_rd_addr = 18'(i);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < int'(L) + 2; k++) tick();
    rec_on = 1'b0;
    chk("burst_pulses", DW'(rec_data.size()), 144'd16);
    for (int i = 0; i < 16 && i < rec_data.size(); i++) begin
      chk("burst_data", rec_data[i], DW'(i));
      chk("burst_gapless", DW'(rec_cyc[i] - rec_cyc[0]), DW'(i));
    end
    chk("burst_busy_end", DW'(busy), 144'd0);
    chk("burst_rd_count", DW'(rd_count), 144'd16);

    // ---- reset with reads in flight ----
    ram_wr_en = 1'b1; ram_wr_addr = 18'd9; ram_wr_data = dead;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      ram_rd_en = 1'b1; ram_rd_addr = 18'(i);
      tick();
    end
    idle_inputs();
    tick(); tick();
    rst = 1'b1; ram_rd_en = 1'b1; ram_wr_en = 1'b1; ram_wr_addr = 18'd9; ram_wr_data = '0;
    tick();
    rst = 1'b0;
    idle_inputs();
    chk("rst_busy", DW'(busy), 144'd0);
    chk("rst_rd_count", DW'(rd_count), 144'd0);
    chk("rst_wr_count", DW'(wr_count), 144'd0);
    rec_data.delete(); rec_cyc.delete();
    rec_on = 1'b1;
    for (int k = 0; k < int'(L) + 4; k++) tick();
    rec_on = 1'b0;
    chk("rst_no_pulses", DW'(rec_data.size()), 144'd0);
    ram_rd_en = 1'b1; ram_rd_addr = 18'd9;
    tick();
    idle_inputs();
    for (int k = 0; k < int'(L); k++) tick();
    chk("rst_keep_valid", DW'(ram_rd_valid), 144'd1);
    chk("rst_keep_data", ram_rd_data, dead);
    tick();

    // ---- RD_LATENCY=1, ADDR_BITS=4 instance ----
    for (int i = 0; i < 16; i++) begin
      b_wr_en = 1'b1; b_wr_addr = 18'(i); b_wr_data = DW'(i + 100);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      b_rd_en = 1'b1; b_rd_addr = 18'(i);
      tick();
      chk("lat1_busy", DW'(b_busy), 144'd1);
      if (i > 0) begin
        chk("lat1_valid", DW'(b_rd_valid), 144'd1);
        chk("lat1_data", b_rd_data, DW'(i - 1 + 100));
      end
    end
    idle_inputs();
    tick();
    chk("lat1_valid", DW'(b_rd_valid), 144'd1);
    chk("lat1_data", b_rd_data, DW'(115));
    chk("lat1_busy_end", DW'(b_busy), 144'd0);
    tick();
    chk("lat1_pulse_end", DW'(b_rd_valid), 144'd0);
    chk("lat1_hold", b_rd_data, DW'(115));
    chk("lat1_rd_count", DW'(b_rd_count), 144'd16);
    chk("lat1_wr_count", DW'(b_wr_count), 144'd16);

    // ---- randomized traffic against the model ----
    for (int a = 0; a < (1 << AB); a++) begin
      ram_wr_en = 1'b1;
      ram_wr_addr = 18'(a) | 18'($urandom_range(0, 255) << AB);
      ram_wr_data = rnd_word();
      tick();
    end
    idle_inputs();
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      ram_rd_en   = 1'($urandom);
      ram_rd_addr = 18'($urandom);
      ram_wr_en   = 1'($urandom);
      ram_wr_addr = ($urandom_range(0, 1) == 0) ? ram_rd_addr : 18'($urandom);
      ram_wr_data = rnd_word();
      fault_en    = 1'($urandom);
      fault_addr  = ($urandom_range(0, 1) == 0) ? ram_rd_addr
                                                : ram_rd_addr ^ 18'(1 << $urandom_range(0, 17));
      fault_mask  = rnd_word();
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < int'(L) + 2; k++) tick();
    chk("final_busy", DW'(busy), 144'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
